// File: rtl/alu_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : alu_arbiter                                                |
// | Description : Round-robin sharing of one combinational ALU between the   |
// |               execute stage (port 0) and the address unit (port 1), with |
// |               operand latching, registered result and the flags register.|
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module alu_arbiter #(
  parameter int DATA_W = 8,
  parameter int OP_W   = 4,
  parameter int FLAG_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [OP_W-1:0]   req0_op,
  input  logic              req0_upd_flags,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [OP_W-1:0]   req1_op,
  output logic              rsp0_valid,
  output logic              rsp1_valid,
  input  logic              rsp0_ready,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp_c,
  output logic [FLAG_W-1:0] rsp_flags,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  output logic [FLAG_W-1:0] alu_cpu_flags,
  input  logic [DATA_W-1:0] alu_c,
  input  logic [FLAG_W-1:0] alu_flags,
  input  logic              flags_wr_en,
  input  logic [FLAG_W-1:0] flags_wr_data,
  output logic [FLAG_W-1:0] flags_q
);

  localparam logic [1:0] C_IDLE = 2'd0;
  localparam logic [1:0] C_EXEC = 2'd1;
  localparam logic [1:0] C_RESP = 2'd2;

  logic [1:0]        state_q,      state_d;
  logic              last_grant_q, last_grant_d;
  logic              id_q,         id_d;
  logic              upd_q,        upd_d;
  logic [DATA_W-1:0] a_q,          a_d;
  logic [DATA_W-1:0] b_q,          b_d;
  logic [OP_W-1:0]   op_q,         op_d;
  logic [DATA_W-1:0] rsp_c_q,      rsp_c_d;
  logic [FLAG_W-1:0] rsp_flags_q,  rsp_flags_d;
  logic [FLAG_W-1:0] flags_d;

  logic w_idle;
  logic w_grant0;
  logic w_grant1;
  logic w_hs0;
  logic w_hs1;
  logic w_rsp_hs;

  // On contention the port that did not win last time is served.
  assign w_idle   = (state_q == C_IDLE);
  assign w_grant0 = req0_valid & (~req1_valid | last_grant_q);
  assign w_grant1 = req1_valid & (~req0_valid | ~last_grant_q);

  // Readies are gated by rst_n so nothing is offered while reset is held.
  assign req0_ready = rst_n & w_idle & w_grant0;
  assign req1_ready = rst_n & w_idle & w_grant1;
  assign w_hs0      = req0_valid & req0_ready;
  assign w_hs1      = req1_valid & req1_ready;

  assign rsp0_valid = (state_q == C_RESP) & ~id_q;
  assign rsp1_valid = (state_q == C_RESP) &  id_q;
  assign w_rsp_hs   = id_q ? rsp1_ready : rsp0_ready;

  assign rsp_c         = rsp_c_q;
  assign rsp_flags     = rsp_flags_q;
  assign alu_a         = a_q;
  assign alu_b         = b_q;
  assign alu_op        = op_q;
  assign alu_cpu_flags = flags_q;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    upd_d        = upd_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    rsp_c_d      = rsp_c_q;
    rsp_flags_d  = rsp_flags_q;
    flags_d      = flags_q;

    case (state_q)
      C_IDLE: begin
        if (w_hs0) begin
          a_d     = req0_a;
          b_d     = req0_b;
          op_d    = req0_op;
          upd_d   = req0_upd_flags;
          id_d    = 1'b0;
          state_d = C_EXEC;
        end else if (w_hs1) begin
          a_d     = req1_a;
          b_d     = req1_b;
          op_d    = req1_op;
          upd_d   = 1'b0;
          id_d    = 1'b1;
          state_d = C_EXEC;
        end
      end
      C_EXEC: begin
        rsp_c_d      = alu_c;
        rsp_flags_d  = alu_flags;
        last_grant_d = id_q;
        if (upd_q) begin
          flags_d = alu_flags;
        end
        state_d = C_RESP;
      end
      C_RESP: begin
        if (w_rsp_hs) begin
          state_d = C_IDLE;
        end
      end
      default: begin
        state_d = C_IDLE;
      end
    endcase

    // A direct flags write overrides any ALU flag update in the same cycle.
    if (flags_wr_en) begin
      flags_d = flags_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= C_IDLE;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      upd_q        <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      rsp_c_q      <= '0;
      rsp_flags_q  <= '0;
      flags_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      upd_q        <= upd_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      rsp_c_q      <= rsp_c_d;
      rsp_flags_q  <= rsp_flags_d;
      flags_q      <= flags_d;
    end
  end

endmodule
`default_nettype wire

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational `alu` instance between two requesters.
  - Port 0: core execute stage.
  - Port 1: address/increment unit.
- Provides round-robin arbitration, operand latching and a registered result.
- Owns the architectural flags register. Only port-0 operations may update it; the register feeds the ALU's `cpu_flags` input.
- Sits between the decode/execute logic and the `alu` in the CPU core.

Parameters:
- DATA_W, 8, operand/result width; must match `alu`.
- OP_W, 4, opcode width; 16 ALU ops.
- FLAG_W, 8, flags width. Bit order MSB..LSB: unused[7:6], overflow[5], parity[4], sign[3], zero[2], aux_carry[1], carry[0].

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  port-0 request valid.
- req0_ready  out  1  port-0 request accepted this cycle.
- req0_a, req0_b  in  DATA_W  port-0 operands.
- req0_op  in  OP_W  port-0 ALU opcode.
- req0_upd_flags  in  1  port-0 result writes flags_q.
- req1_valid  in  1  port-1 request valid.
- req1_ready  out  1  port-1 request accepted this cycle.
- req1_a, req1_b  in  DATA_W  port-1 operands.
- req1_op  in  OP_W  port-1 ALU opcode; never updates flags.
- rsp0_valid, rsp1_valid  out  1  response valid per port.
- rsp0_ready, rsp1_ready  in  1  response consumed per port.
- rsp_c  out  DATA_W  registered ALU result (shared by both response ports).
- rsp_flags  out  FLAG_W  registered ALU flags for that operation.
- alu_a, alu_b  out  DATA_W  to `alu` .a/.b.
- alu_op  out  OP_W  to `alu` .op.
- alu_cpu_flags  out  FLAG_W  to `alu` .cpu_flags; equals flags_q.
- alu_c  in  DATA_W  from `alu` .c.
- alu_flags  in  FLAG_W  from `alu` .flags.
- flags_wr_en  in  1  direct flags write (e.g. flag-restore instruction).
- flags_wr_data  in  FLAG_W  direct flags write value.
- flags_q  out  FLAG_W  architectural flags register.

Behaviour:
- Reset (async, rst_n=0), all outputs and registers go to 0:
  - state=IDLE, flags_q, alu_a/b/op, rsp_c, rsp_flags, rsp*_valid, req*_ready.
  - last_grant=1, so port 0 wins the first contest.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant is combinational from the valid lines and last_grant.
  - Only one valid: that port is granted.
  - Both valid: the port != last_grant is granted.
  - reqN_ready=1 only for the granted port, only in IDLE; never both.
  - On handshake: latch a, b, op, upd_flags (forced 0 for port 1) and id; go to EXEC.
- EXEC (exactly one cycle):
  - alu_a/alu_b/alu_op driven from the latched regs; alu_cpu_flags = flags_q.
  - At the clock edge: rsp_c<=alu_c, rsp_flags<=alu_flags, last_grant<=id; go to RESP.
  - If upd: flags_q<=alu_flags.
- RESP:
  - rsp<id>_valid=1; the other rsp valid stays 0.
  - rsp_c/rsp_flags are held stable until the handshake.
  - On rsp<id>_ready=1: go to IDLE; valid drops next cycle.
  - No new request is accepted while in RESP.
- alu_a/b/op hold their last latched value outside EXEC; they are not zeroed.
- Latency: accept at cycle T, EXEC at T+1, rsp_valid from T+2. Maximum throughput is 1 op per 3 cycles.
- Requester rules:
  - Once valid is asserted, it and its payload stay stable until ready.
  - Dropping valid before ready is allowed and the request is simply not served.
- flags_wr_en:
  - In any state, flags_q<=flags_wr_data at the next edge.
  - If it coincides with an EXEC flag update, flags_wr_en wins.
- Chained port-0 ops see the flags_q written by the previous port-0 op (e.g. ADD then ADD with carry-in via cpu_flags).
- Reset mid-operation: the in-flight op is discarded, no response is issued, and flags_q is cleared.

Test Plan:
- Port-0 ADD a=8'hCA b=8'hAA upd=1:
  - req0_ready at T; rsp0_valid at T+2 with rsp_c=8'h74 and rsp_flags carry(bit0)=1, zero(bit2)=0.
  - flags_q==rsp_flags at T+2.
- Port-1 AND a=8'hCA b=8'hAA with flags_q preloaded to 8'h3F:
  - rsp1 shows rsp_c=8'h8A.
  - flags_q stays 8'h3F.
- Both valid continuously for 4 ops from reset: grant order is 0,1,0,1; rsp order matches; never both readies high.
- rsp0_ready held low 5 cycles in RESP:
  - rsp0_valid, rsp_c and rsp_flags stay stable.
  - req1_valid=1 but req1_ready stays 0 until release.
- flags_wr_en=1, flags_wr_data=8'h21 in the same EXEC cycle as a port-0 upd op: flags_q=8'h21 afterwards.
- rst_n pulsed low during EXEC: all outputs are 0 immediately, no rsp_valid ever appears, and the next request is accepted normally.
